// File: rtl/lab4_pkg.sv
// Shared definitions for the binary search block: default widths, FSM state type
// and the memory image the search RAM powers up with.
package lab4_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_CMP, S_DONE} bs_state_t;

  typedef logic [DATA_W_DEF-1:0] mem_image_t [DEPTH];

  // Ascending, duplicate-free image: word i holds 2*i.
  function automatic mem_image_t ramp_image();
    mem_image_t img;
    for (int i = 0; i < DEPTH; i++) img[i] = DATA_W_DEF'(2 * i);
    return img;
  endfunction
endpackage

// File: rtl/ram32x8.sv
// 32x8 search memory: registered address, data valid the cycle after the address.
// The write side is permanently disabled, so contents come only from the INIT image.
module ram32x8
  import lab4_pkg::*;
#(
  parameter mem_image_t INIT = ramp_image()
) (
  input  logic                  clk,
  input  logic [ADDR_W_DEF-1:0] addr,
  output logic [DATA_W_DEF-1:0] rdata
);
  logic [ADDR_W_DEF-1:0] addr_q;

  // No reset here: the image must survive a controller reset.
  always_ff @(posedge clk) begin
    addr_q <= addr;
  end

  assign rdata = INIT[addr_q];
endmodule

// File: rtl/binary_search.sv
// Binary search controller and datapath over a sorted 32x8 memory. Each probe is
// READ (issue mid), WAIT (memory latency), CMP (narrow or finish).
module binary_search
  import lab4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  output logic              found,
  output logic              done,
  output logic [ADDR_W-1:0] loc
);
  bs_state_t         state, state_n;
  logic [DATA_W-1:0] key, key_n;
  logic [ADDR_W-1:0] low, low_n, high, high_n, mid, mid_n;
  logic              found_n, done_n;
  logic [ADDR_W-1:0] loc_n;
  logic [ADDR_W:0]   sum;
  logic [ADDR_W-1:0] mid_calc, mem_addr;
  logic [DATA_W-1:0] mem_data;

  // One extra bit so low+high never wraps before halving.
  assign sum      = {1'b0, low} + {1'b0, high};
  assign mid_calc = ADDR_W'(sum >> 1);

  ram32x8 u_ram (
    .clk   (clk),
    .addr  (mem_addr),
    .rdata (mem_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      key   <= '0;
      low   <= '0;
      high  <= '1;
      mid   <= '0;
      found <= 1'b0;
      done  <= 1'b0;
      loc   <= '0;
    end else begin
      state <= state_n;
      key   <= key_n;
      low   <= low_n;
      high  <= high_n;
      mid   <= mid_n;
      found <= found_n;
      done  <= done_n;
      loc   <= loc_n;
    end
  end

  always_comb begin
    state_n  = state;
    key_n    = key;
    low_n    = low;
    high_n   = high;
    mid_n    = mid;
    found_n  = 1'b0;
    done_n   = 1'b0;
    loc_n    = '0;
    mem_addr = mid;
    case (state)
      S_IDLE: begin
        key_n  = A;
        low_n  = '0;
        high_n = '1;
        if (start) state_n = S_READ;
      end
      S_READ: begin
        mid_n    = mid_calc;
        mem_addr = mid_calc;
        state_n  = S_WAIT;
      end
      S_WAIT: state_n = S_CMP;
      S_CMP: begin
        // The mid==low / mid==high guards stop the window from crossing 0 or 31.
        if (mem_data == key) begin
          found_n = 1'b1;
          loc_n   = mid;
          done_n  = 1'b1;
          state_n = S_DONE;
        end else if (key < mem_data) begin
          if (mid == low) begin
            done_n  = 1'b1;
            state_n = S_DONE;
          end else begin
            high_n  = mid - ADDR_W'(1);
            state_n = S_READ;
          end
        end else begin
          if (mid == high) begin
            done_n  = 1'b1;
            state_n = S_DONE;
          end else begin
            low_n   = mid + ADDR_W'(1);
            state_n = S_READ;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          found_n = found;
          loc_n   = loc;
          done_n  = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule
